// File: rtl/gpu_pkg.sv
// Shared 2D GPU pipeline types: shape command codes and sequencer states.
package gpu_pkg;

  typedef enum logic [3:0] {
    LINE     = 4'd0,
    POLYGON  = 4'd1,
    ARC      = 4'd2,
    POLYLINE = 4'd3
  } shape_e;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/shape_sequencer_edge_counter.sv
// Edge/segment index counter: load a last-index bound, step, flag the final edge.
module edge_counter #(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load_i,
  input  logic [IDX_W-1:0] last_idx_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o
);

  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] bound_q, bound_d;

  // The bound is stored as total-1 so a full MAX_VERTS/ARC_SEGS count fits IDX_W.
  always_comb begin
    index_d = index_q;
    bound_d = bound_q;
    if (load_i) begin
      index_d = '0;
      bound_d = last_idx_i;
    end else if (inc_i && !last_o) begin
      index_d = index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      index_q <= '0;
      bound_q <= '0;
    end else begin
      index_q <= index_d;
      bound_q <= bound_d;
    end
  end

  assign index_o = index_q;
  assign last_o  = (index_q == bound_q);

endmodule

// File: rtl/shape_sequencer.sv
// Shape command sequencer: decodes one shape and walks its edges/arc segments
// through the rasteriser handshake, pixel-FIFO drain and completion pulse.
module shape_sequencer
  import gpu_pkg::*;
#(
  parameter int unsigned MAX_VERTS = 8,
  parameter int unsigned ARC_SEGS  = 8,
  parameter int unsigned IDX_W     = $clog2(MAX_VERTS > ARC_SEGS ? MAX_VERTS : ARC_SEGS),
  parameter int unsigned NV_W      = $clog2(MAX_VERTS + 1)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_shapeid,
  input  logic [NV_W-1:0]  cmd_nverts,
  output logic             prim_valid,
  input  logic             prim_ready,
  output logic             prim_sel,
  output logic [IDX_W-1:0] prim_index,
  output logic             prim_close,
  input  logic             prim_done,
  output logic             fifo_read,
  output logic             shape_done,
  output logic             busy,
  output logic             err
);

  seq_state_e       state_q, state_d;
  logic [3:0]       shapeid_q, shapeid_d;
  logic [NV_W-1:0]  nverts_q, nverts_d;
  logic             err_q, err_d;

  logic             legal;
  logic [IDX_W-1:0] last_idx;
  logic             ctr_load, ctr_inc;
  logic [IDX_W-1:0] index;
  logic             is_last;

  always_comb begin
    legal    = 1'b0;
    last_idx = '0;
    case (shapeid_q)
      LINE: begin
        legal = 1'b1;
      end
      POLYGON: begin
        legal    = (nverts_q >= NV_W'(3)) && (nverts_q <= NV_W'(MAX_VERTS));
        last_idx = IDX_W'(nverts_q - NV_W'(1));
      end
      POLYLINE: begin
        legal    = (nverts_q >= NV_W'(2)) && (nverts_q <= NV_W'(MAX_VERTS));
        last_idx = IDX_W'(nverts_q - NV_W'(2));
      end
      ARC: begin
        legal    = 1'b1;
        last_idx = IDX_W'(ARC_SEGS - 1);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shapeid_d = shapeid_q;
    nverts_d  = nverts_q;
    err_d     = err_q;
    ctr_load  = 1'b0;
    ctr_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          shapeid_d = cmd_shapeid;
          nverts_d  = cmd_nverts;
          err_d     = 1'b0;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        if (legal) begin
          ctr_load = 1'b1;
          state_d  = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      ISSUE: if (prim_ready) state_d = WAIT;
      WAIT:  if (prim_done)  state_d = DRAIN;
      DRAIN: begin
        if (is_last) begin
          state_d = DONE;
        end else begin
          ctr_inc = 1'b1;
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      shapeid_q <= '0;
      nverts_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shapeid_q <= shapeid_d;
      nverts_q  <= nverts_d;
      err_q     <= err_d;
    end
  end

  edge_counter #(
    .IDX_W (IDX_W)
  ) u_edge_counter (
    .clk        (clk),
    .nreset     (nreset),
    .load_i     (ctr_load),
    .last_idx_i (last_idx),
    .inc_i      (ctr_inc),
    .index_o    (index),
    .last_o     (is_last)
  );

  // Primitive fields are only driven while a request is outstanding.
  assign cmd_ready  = (state_q == IDLE);
  assign prim_valid = (state_q == ISSUE);
  assign prim_index = (state_q == ISSUE) ? index : '0;
  assign prim_sel   = (state_q == ISSUE) && (shapeid_q == ARC);
  assign prim_close = (state_q == ISSUE) && (shapeid_q == POLYGON) && is_last;
  assign fifo_read  = (state_q == DRAIN);
  assign shape_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_shape_sequencer.sv
// Directed scoreboard bench for shape_sequencer: expected primitives are queued
// at command issue and retired against each observed prim_valid.
module tb_shape_sequencer;

  localparam int unsigned MAX_VERTS = 8;
  localparam int unsigned ARC_SEGS  = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned NV_W      = 4;

  logic             clk;
  logic             nreset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_shapeid;
  logic [NV_W-1:0]  cmd_nverts;
  logic             prim_valid;
  logic             prim_ready;
  logic             prim_sel;
  logic [IDX_W-1:0] prim_index;
  logic             prim_close;
  logic             prim_done;
  logic             fifo_read;
  logic             shape_done;
  logic             busy;
  logic             err;

  typedef struct {
    logic        sel;
    logic [31:0] idx;
    logic        close;
  } prim_t;

  prim_t exp_q[$];
  int    vectors;
  int    miscompares;

  shape_sequencer #(
    .MAX_VERTS (MAX_VERTS),
    .ARC_SEGS  (ARC_SEGS)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_shapeid (cmd_shapeid),
    .cmd_nverts  (cmd_nverts),
    .prim_valid  (prim_valid),
    .prim_ready  (prim_ready),
    .prim_sel    (prim_sel),
    .prim_index  (prim_index),
    .prim_close  (prim_close),
    .prim_done   (prim_done),
    .fifo_read   (fifo_read),
    .shape_done  (shape_done),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prim_valid"}, prim_valid, 0);
    chk({tag, "_fifo_read"},  fifo_read, 0);
    chk({tag, "_shape_done"}, shape_done, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_err"},        err, 0);
    chk({tag, "_prim_index"}, prim_index, 0);
    chk({tag, "_prim_close"}, prim_close, 0);
    chk({tag, "_prim_sel"},   prim_sel, 0);
    chk({tag, "_cmd_ready"},  cmd_ready, 1);
  endtask

  // Reference model of the edge list a command should produce.
  task automatic build_expect(input int sid, input int nv, output bit e);
    prim_t p;
    e = 1'b0;
    exp_q.delete();
    case (sid)
      0: begin p.sel = 0; p.idx = 0; p.close = 0; exp_q.push_back(p); end
      1: if (nv >= 3 && nv <= int'(MAX_VERTS)) begin
           for (int i = 0; i < nv; i++) begin
             p.sel = 0; p.idx = i; p.close = (i == nv - 1); exp_q.push_back(p);
           end
         end else e = 1'b1;
      2: for (int i = 0; i < int'(ARC_SEGS); i++) begin
           p.sel = 1; p.idx = i; p.close = 0; exp_q.push_back(p);
         end
      3: if (nv >= 2 && nv <= int'(MAX_VERTS)) begin
           for (int i = 0; i < nv - 1; i++) begin
             p.sel = 0; p.idx = i; p.close = 0; exp_q.push_back(p);
           end
         end else e = 1'b1;
      default: e = 1'b1;
    endcase
  endtask

  task automatic run_cmd(input int sid, input int nv, input int stall, input int done_delay,
                         input bit hold_valid, input int abort_idx, input bit line_lat);
    bit exp_err, finished, aborted, done_pend;
    bit exp_pv, exp_fr, exp_sd, nx_pv, nx_fr, nx_sd;
    int exp_edges, fr_cnt, cyc, stall_cnt, wait_cnt, last_idx, t_pv, t_fr, t_done;
    build_expect(sid, nv, exp_err);
    exp_edges = exp_q.size();
    finished = 0; aborted = 0; done_pend = 0;
    exp_pv = 0; exp_fr = 0; exp_sd = 0;
    fr_cnt = 0; cyc = 0; stall_cnt = 0; wait_cnt = 0; last_idx = -1;
    t_pv = -1; t_fr = -1; t_done = -1;
    @(negedge clk);
    chk("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_shapeid = 4'(sid); cmd_nverts = NV_W'(nv);
    while (!finished && !aborted && cyc < 300) begin
      @(negedge clk); cyc++;
      if (hold_valid) cmd_shapeid = 4'd7; else cmd_valid = 1'b0;
      if (cyc == 1) chk("err_cleared", err, 0);
      chk("busy", busy, 1);
      chk("ready_while_busy", cmd_ready, 0);
      chk("prim_valid", prim_valid, exp_pv);
      chk("fifo_read", fifo_read, exp_fr);
      chk("shape_done", shape_done, exp_sd);
      nx_pv = 0; nx_fr = 0; nx_sd = 0;
      prim_ready = 1'b0; prim_done = 1'b0;
      if (cyc == 1) begin
        if (exp_err) nx_sd = 1; else nx_pv = 1;
      end
      if (fifo_read) begin
        fr_cnt++;
        if (t_fr < 0) t_fr = cyc;
        if (fr_cnt >= exp_edges) nx_sd = 1; else nx_pv = 1;
      end
      if (shape_done) begin
        finished = 1; t_done = cyc;
        if (hold_valid) cmd_valid = 1'b0;
      end
      if (prim_valid) begin
        if (t_pv < 0) t_pv = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_prim", prim_valid, 0);
          prim_ready = 1'b1;
        end else begin
          chk("prim_sel", prim_sel, exp_q[0].sel);
          chk("prim_index", prim_index, exp_q[0].idx);
          chk("prim_close", prim_close, exp_q[0].close);
          if (stall_cnt < stall) begin
            stall_cnt++;
            prim_done = 1'b1;  // must be ignored outside WAIT
            nx_pv = 1;
          end else begin
            prim_ready = 1'b1;
            last_idx = int'(exp_q[0].idx);
            void'(exp_q.pop_front());
            stall_cnt = 0; wait_cnt = 0; done_pend = 1;
          end
        end
      end else if (done_pend) begin
        if (abort_idx >= 0 && last_idx == abort_idx) begin
          nreset = 1'b0; aborted = 1; done_pend = 0;
        end else if (wait_cnt < done_delay) begin
          wait_cnt++;
        end else begin
          prim_done = 1'b1; done_pend = 0; nx_fr = 1;
        end
      end
      exp_pv = nx_pv; exp_fr = nx_fr; exp_sd = nx_sd;
    end
    cmd_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      chk_reset_outputs("abort_in_reset");
      nreset = 1'b1;
      @(negedge clk);
      chk_reset_outputs("abort_released");
      exp_q.delete();
    end else begin
      chk("finished_in_budget", finished, 1);
      chk("edge_count", fr_cnt, exp_edges);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("err_at_done", err, exp_err);
      if (line_lat) begin
        chk("line_prim_valid_cycle", t_pv, 2);
        chk("line_fifo_read_cycle", t_fr, 4);
        chk("line_shape_done_cycle", t_done, 5);
      end
      @(negedge clk);
      chk("ready_after_done", cmd_ready, 1);
      chk("idle_not_busy", busy, 0);
      chk("single_done_pulse", shape_done, 0);
      exp_q.delete();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    nreset = 1'b0; cmd_valid = 1'b0; cmd_shapeid = '0; cmd_nverts = '0;
    prim_ready = 1'b0; prim_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    nreset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // LINE at minimum latency
    run_cmd(0, 0, 0, 0, 1'b0, -1, 1'b1);
    // POLYGON n=4 with cmd_valid held high (and a changing shapeid) while busy
    run_cmd(1, 4, 0, 0, 1'b1, -1, 1'b0);
    // ARC with 3-cycle accept stall and delayed completion
    run_cmd(2, 0, 3, 2, 1'b0, -1, 1'b0);
    // POLYLINE n=2: single open edge
    run_cmd(3, 2, 0, 0, 1'b0, -1, 1'b0);
    // POLYGON n=2: too few vertices
    run_cmd(1, 2, 0, 0, 1'b0, -1, 1'b0);
    // illegal shape code; err must persist while idle
    run_cmd(7, 0, 0, 0, 1'b0, -1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", err, 1);
    end
    run_cmd(0, 0, 1, 1, 1'b0, -1, 1'b0);
    // POLYGON n=5 reset during WAIT of the second edge, then resume normally
    run_cmd(1, 5, 0, 0, 1'b0, 1, 1'b0);
    run_cmd(3, 8, 1, 0, 1'b0, -1, 1'b0);
    // boundary vertex counts
    run_cmd(1, 8, 0, 0, 1'b0, -1, 1'b0);
    run_cmd(1, 9, 0, 0, 1'b0, -1, 1'b0);
    run_cmd(3, 1, 0, 0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
